adder_rr_arbiter: RTL

- Round-robin arbiter that shares one pipelined WIDTH-bit adder between NUM_REQ requesters.
- Each requester presents operands with a request. The block grants one requester per cycle, registers that requester's operands onto the adder's a/b/valid inputs, and tags each operation with the requester ID.
- When the adder's sum returns, the block routes it back with the matching ID.
- It sits between client logic and the adder's DUT-side port.

---
 rtl/adder_rr_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined adder between NUM_REQ requesters.
// Each issued operation carries its requester ID down a tag pipe that lines up with the adder result.
module adder_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int ADDER_LAT = 1,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  output logic                       add_valid,
  input  logic [WIDTH:0]             add_sum,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH:0]             rsp_sum,
  output logic                       busy
);

  logic [IDW-1:0]                 r_ptr;
  logic [WIDTH-1:0]               r_add_a, r_add_b;
  logic [ADDER_LAT:0]             r_vld_pipe;
  logic [ADDER_LAT:0][IDW-1:0]    r_id_pipe;

  logic                           w_hit;
  logic [IDW-1:0]                 w_win, w_cand, w_ptr_nxt;
  logic [NUM_REQ-1:0]             w_gnt;
  logic [WIDTH-1:0]               w_sel_a, w_sel_b;
  int                             w_idx;

  // Scan offsets high to low so the lowest offset from ptr is the last, winning write.
  always_comb begin
    w_hit  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    w_idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx  = (int'(r_ptr) + k) % NUM_REQ;
      w_cand = IDW'(w_idx);
      if (req[w_cand]) begin
        w_hit = 1'b1;
        w_win = w_cand;
      end
    end
    w_hit = w_hit & en & ~rst;
    w_gnt = '0;
    if (w_hit) w_gnt[w_win] = 1'b1;
  end

  assign w_ptr_nxt = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + IDW'(1);
  assign w_sel_a   = req_a[w_win*WIDTH +: WIDTH];
  assign w_sel_b   = req_b[w_win*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe[0] <= w_hit;
      r_id_pipe[0]  <= w_hit ? w_win : '0;
      if (w_hit) begin
        r_ptr   <= w_ptr_nxt;
        r_add_a <= w_sel_a;
        r_add_b <= w_sel_b;
      end
      for (int k = 1; k <= ADDER_LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_id_pipe[k]  <= r_id_pipe[k-1];
      end
    end
  end

  assign gnt       = w_gnt;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_valid = r_vld_pipe[0];
  assign rsp_valid = r_vld_pipe[ADDER_LAT];
  assign rsp_id    = r_id_pipe[ADDER_LAT];
  assign rsp_sum   = add_sum;
  assign busy      = |r_vld_pipe;

endmodule
